// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the MMU data-port arbiter: response owner encoding
// and the idle byte-enable value.
package dm_arb_defs;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_M0   = 2'd1,
    OWNER_M1   = 2'd2
  } owner_e;

  localparam logic [3:0] BE_IDLE = 4'b0000;

endpackage

// File: rtl/dm_port_arbiter_starve_timer.sv
// Counts consecutive refused M1 cycles and requests a forced M1 grant once
// the count reaches MAX_WAIT.
module starve_timer
  import dm_arb_defs::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic resetb,
  input  logic req,
  input  logic gnt,
  output logic force_grant
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    if (req && !gnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_CNT) ? MAX_CNT : wait_cnt_q + 1'b1;
    end
  end

  assign force_grant = req && (wait_cnt_q == MAX_CNT);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single MMU data port: fixed priority to M0 with
// starvation relief for M1, and 1-cycle read response routing.
module dm_port_arbiter
  import dm_arb_defs::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  input  logic        m0_signed,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  input  logic        m1_signed,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_di,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic        is_signed,
  input  logic [31:0] dm_do
);

  owner_e owner_q;
  owner_e owner_d;
  logic   force_grant;

  starve_timer #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_starve_timer (
    .clk        (clk),
    .resetb     (resetb),
    .req        (m1_req),
    .gnt        (m1_gnt),
    .force_grant(force_grant)
  );

  // Grants depend only on request lines, so idle payload X cannot reach them.
  always_comb begin
    m1_gnt = m1_req && (!m0_req || force_grant);
    m0_gnt = m0_req && !m1_gnt;
  end

  always_comb begin
    dm_addr   = '0;
    dm_di     = '0;
    dm_we     = 1'b0;
    dm_be     = BE_IDLE;
    is_signed = 1'b0;
    if (m0_gnt) begin
      dm_addr   = m0_addr;
      dm_di     = m0_wdata;
      dm_we     = m0_we;
      dm_be     = m0_be;
      is_signed = m0_signed;
    end else if (m1_gnt) begin
      dm_addr   = m1_addr;
      dm_di     = m1_wdata;
      dm_we     = m1_we;
      dm_be     = m1_be;
      is_signed = m1_signed;
    end
  end

  always_comb begin
    owner_d = OWNER_NONE;
    if (m0_gnt && !m0_we) begin
      owner_d = OWNER_M0;
    end else if (m1_gnt && !m1_we) begin
      owner_d = OWNER_M1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign m0_rvalid = (owner_q == OWNER_M0);
  assign m1_rvalid = (owner_q == OWNER_M1);
  assign m0_rdata  = m0_rvalid ? dm_do : '0;
  assign m1_rdata  = m1_rvalid ? dm_do : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios followed by
// random traffic, all checked against a behavioural model.
module tb_dm_port_arbiter;

  localparam int MW = 4;

  logic        clk;
  logic        resetb;
  logic        m0_req, m0_we, m0_signed, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_signed, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic [31:0] dm_addr, dm_di, dm_do;
  logic        dm_we, is_signed;
  logic [3:0]  dm_be;

  int total;
  int bad;

  // Model state: consecutive refused M1 cycles, and who owns the pending read
  // (0 none, 1 M0, 2 M1).
  int lost;
  int exp_owner;
  logic last_g0, last_g1;
  logic obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [31:0] obs_rd0;

  logic [3:0] be_tab [7] = '{4'b1111, 4'b1100, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  dm_port_arbiter #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk(clk), .resetb(resetb),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_signed(m0_signed), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_signed(m1_signed), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_di(dm_di), .dm_we(dm_we), .dm_be(dm_be),
    .is_signed(is_signed), .dm_do(dm_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic sg);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_be = be; m0_signed = sg;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic sg);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_be = be; m1_signed = sg;
  endtask

  task automatic idle0();
    m0_req = 1'b0; m0_we = 1'bx; m0_addr = 'x; m0_wdata = 'x; m0_be = 'x; m0_signed = 1'bx;
  endtask

  task automatic idle1();
    m1_req = 1'b0; m1_we = 1'bx; m1_addr = 'x; m1_wdata = 'x; m1_be = 'x; m1_signed = 1'bx;
  endtask

  task automatic rnd0();
    drive0(1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
           be_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
  endtask

  task automatic rnd1();
    drive1(1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
           be_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
  endtask

  // One clock: check every output at the falling edge against the model,
  // then advance the model across the rising edge.
  task automatic cycle();
    logic e_g0, e_g1, e_we, e_sg, e_rv0, e_rv1;
    logic [31:0] e_addr, e_di;
    logic [3:0]  e_be;
    dm_do = $urandom();
    @(negedge clk);
    if (!resetb) begin
      lost = 0;
      exp_owner = 0;
    end
    e_g1 = m1_req && (m0_req !== 1'b1 || lost >= MW);
    e_g0 = m0_req && !e_g1;
    e_addr = 0; e_di = 0; e_we = 0; e_be = 0; e_sg = 0;
    if (e_g0) begin
      e_addr = m0_addr; e_di = m0_wdata; e_we = m0_we; e_be = m0_be; e_sg = m0_signed;
    end else if (e_g1) begin
      e_addr = m1_addr; e_di = m1_wdata; e_we = m1_we; e_be = m1_be; e_sg = m1_signed;
    end
    e_rv0 = (exp_owner == 1);
    e_rv1 = (exp_owner == 2);
    chk("m0_gnt", m0_gnt, e_g0);
    chk("m1_gnt", m1_gnt, e_g1);
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_di", dm_di, e_di);
    chk("dm_we", dm_we, e_we);
    chk("dm_be", dm_be, e_be);
    chk("is_signed", is_signed, e_sg);
    chk("m0_rvalid", m0_rvalid, e_rv0);
    chk("m1_rvalid", m1_rvalid, e_rv1);
    chk("m0_rdata", m0_rdata, e_rv0 ? dm_do : 32'h0);
    chk("m1_rdata", m1_rdata, e_rv1 ? dm_do : 32'h0);
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata;
    @(posedge clk);
    if (resetb) begin
      if (m1_req && !e_g1) lost = (lost + 1 > MW) ? MW : lost + 1;
      else lost = 0;
      exp_owner = (e_g0 && !m0_we) ? 1 : (e_g1 && !m1_we) ? 2 : 0;
    end else begin
      lost = 0;
      exp_owner = 0;
    end
    last_g0 = e_g0;
    last_g1 = e_g1;
    #2;
  endtask

  initial begin
    total = 0; bad = 0; lost = 0; exp_owner = 0;
    last_g0 = 0; last_g1 = 0;
    resetb = 1'b0;
    dm_do = '0;
    idle0(); idle1();

    // Reset with no requests: idle port, no responses
    cycle();
    chk("rst_be_idle", dm_be, 4'b0000);
    chk("rst_rv0", obs_rv0, 1'b0);
    cycle();
    resetb = 1'b1;
    cycle();

    // M0 only read
    drive0(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'b1111, 1'b0);
    cycle();
    chk("m0_only_gnt", obs_g0, 1'b1);
    idle0();
    cycle();
    chk("m0_only_rv", obs_rv0, 1'b1);
    chk("m0_only_rdata", obs_rd0, dm_do);

    // M1 only signed byte load
    drive1(1'b1, 1'b0, 32'h8000_0001, 32'h0, 4'b0010, 1'b1);
    cycle();
    chk("m1_only_gnt", obs_g1, 1'b1);
    idle1();
    cycle();
    chk("m1_only_rv", obs_rv1, 1'b1);

    // Continuous contention: M0 x4 then M1, repeating
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 4'b1111, 1'b0);
      drive1(1'b1, 1'b0, 32'h200 + 32'(i), 32'h0, 4'b0011, 1'b0);
      cycle();
      chk("cont_pattern", obs_g1, 1'((i % 5) == 4));
    end
    idle0(); idle1();
    cycle();

    // Write then read on the other master
    drive0(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'b1111, 1'b0);
    cycle();
    idle0();
    drive1(1'b1, 1'b0, 32'h44, 32'h0, 4'b1111, 1'b0);
    cycle();
    chk("mix_no_rv0", obs_rv0, 1'b0);
    chk("mix_no_rv1", obs_rv1, 1'b0);
    idle1();
    cycle();
    chk("mix_rv1", obs_rv1, 1'b1);
    chk("mix_rd0_zero", obs_rd0, 32'h0);

    // Abort: M1 loses 2 cycles, drops, then must wait the full MAX_WAIT again
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, 1'b1, 32'h80, 32'(i), 4'b1111, 1'b0);
      if (i == 2) idle1();
      else drive1(1'b1, 1'b1, 32'h90, 32'h0, 4'b0001, 1'b0);
      cycle();
      if (i >= 3) chk("abort_wait", obs_g1, 1'(i == 7));
    end
    idle0(); idle1();
    cycle();

    // Reset asserted while an M0 read is outstanding
    drive0(1'b1, 1'b0, 32'h1000_0008, 32'h0, 4'b1111, 1'b0);
    cycle();
    idle0();
    resetb = 1'b0;
    cycle();
    chk("rst_mid_rv0", obs_rv0, 1'b0);
    chk("rst_mid_be", dm_be, 4'b0000);
    resetb = 1'b1;
    cycle();
    chk("rst_rel_rv0", obs_rv0, 1'b0);

    // Random traffic; requests hold their payload until granted or aborted
    for (int i = 0; i < 600; i++) begin
      if (m0_req && !last_g0) begin
        if ($urandom_range(0, 19) == 0) idle0();
      end else if ($urandom_range(0, 9) < 7) rnd0();
      else idle0();
      if (m1_req && !last_g1) begin
        if ($urandom_range(0, 19) == 0) idle1();
      end else if ($urandom_range(0, 9) < 6) rnd1();
      else idle1();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
